// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - pipeline execute stage: single-cycle ALU plus 32-step shift-add multiplier
//
// Ports:
//   clk, rst         clock and synchronous active-low reset
//   in_valid         EX latch holds an instruction
//   alu_src_reg      operand B select (0 = rt_data, 1 = sign-extended imm)
//   alu_op_reg       6-bit operation code
//   reg_dst_reg      destination select (0 = rt_addr, 1 = rd_addr)
//   rs_data, rt_data register operands
//   imm              16-bit immediate, shamt = imm[10:6]
//   rt_addr, rd_addr candidate write-back addresses
//   out_ready        MEM latch accepts the output this cycle
//   stall            upstream must hold the EX latch and ID stage
//   out_valid        result, wr_addr, zero and ovf are valid
//   result, wr_addr, zero, ovf   registered output fields
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        alu_src_reg,
    input  logic [5:0]  alu_op_reg,
    input  logic        reg_dst_reg,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic        out_ready,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [4:0]  wr_addr,
    output logic        zero,
    output logic        ovf
);

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_NOR  = 6'h05;
    localparam logic [5:0] OP_SLT  = 6'h06;
    localparam logic [5:0] OP_SLTU = 6'h07;
    localparam logic [5:0] OP_SLL  = 6'h08;
    localparam logic [5:0] OP_SRL  = 6'h09;
    localparam logic [5:0] OP_SRA  = 6'h0A;
    localparam logic [5:0] OP_LUI  = 6'h0B;
    localparam logic [5:0] OP_MUL  = 6'h0C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  mul_wr_q, mul_wr_d;

    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic [4:0]  dst_addr;
    logic [31:0] add_res, sub_res;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        is_mul;
    logic        accept;
    logic        alu_load;
    logic        mul_start;
    logic        mul_load;

    // Operand selection and single-cycle ALU
    always_comb begin
        op_a     = rs_data;
        op_b     = alu_src_reg ? {{16{imm[15]}}, imm} : rt_data;
        shamt    = imm[10:6];
        dst_addr = reg_dst_reg ? rd_addr : rt_addr;
        add_res  = op_a + op_b;
        sub_res  = op_a - op_b;
        alu_res  = 32'h0;
        alu_ovf  = 1'b0;
        case (alu_op_reg)
            OP_ADD: begin
                alu_res = add_res;
                // Same-sign operands producing a result of the other sign
                alu_ovf = (op_a[31] == op_b[31]) && (add_res[31] != op_a[31]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (op_a[31] != op_b[31]) && (sub_res[31] != op_a[31]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {31'h0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {31'h0, op_a < op_b};
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_SRA:  alu_res = $signed(op_b) >>> shamt;
            OP_LUI:  alu_res = {imm, 16'h0};
            default: alu_res = 32'h0;
        endcase
    end

    // Handshake qualifiers
    always_comb begin
        is_mul    = (alu_op_reg == OP_MUL);
        accept    = in_valid && (state_q == S_IDLE) && (!out_valid_q || out_ready);
        alu_load  = accept && !is_mul;
        mul_start = accept && is_mul;
        mul_load  = (state_q == S_DONE) && (!out_valid_q || out_ready);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mul_start) state_d = S_MUL;
            S_MUL:  if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: if (mul_load) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs; stall is forced low while reset is asserted
    always_comb begin
        stall = rst && ((in_valid && !accept) || (state_q != S_IDLE));
    end

    // Multiplier datapath and output register next-state
    always_comb begin
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mul_wr_d    = mul_wr_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        wr_addr_d   = wr_addr_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;

        if (mul_start) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = 32'h0;
            cnt_d    = 5'd0;
            mul_wr_d = dst_addr;
        end else if (state_q == S_MUL) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
        end

        // A held result may leave on the same edge a new one is loaded
        if (alu_load) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            wr_addr_d   = dst_addr;
            zero_d      = (alu_res == 32'h0);
            ovf_d       = alu_ovf;
        end else if (mul_load) begin
            out_valid_d = 1'b1;
            result_d    = acc_q;
            wr_addr_d   = mul_wr_q;
            zero_d      = (acc_q == 32'h0);
            ovf_d       = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'h0;
            wr_addr_q   <= 5'h0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mcand_q     <= 32'h0;
            mplier_q    <= 32'h0;
            acc_q       <= 32'h0;
            cnt_q       <= 5'h0;
            mul_wr_q    <= 5'h0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            wr_addr_q   <= wr_addr_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mul_wr_q    <= mul_wr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign wr_addr   = wr_addr_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        alu_src_reg;
    logic [5:0]  alu_op_reg;
    logic        reg_dst_reg;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic [4:0]  rt_addr, rd_addr;
    logic        out_ready;
    logic        stall, out_valid, zero, ovf;
    logic [31:0] result;
    logic [4:0]  wr_addr;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_src_reg(alu_src_reg),
        .alu_op_reg(alu_op_reg), .reg_dst_reg(reg_dst_reg), .rs_data(rs_data),
        .rt_data(rt_data), .imm(imm), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .out_ready(out_ready), .stall(stall), .out_valid(out_valid),
        .result(result), .wr_addr(wr_addr), .zero(zero), .ovf(ovf)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        z;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: arithmetic straight from the instruction semantics
    function automatic exp_t model(input logic [5:0] op, input logic src, input logic dst,
                                   input logic [31:0] a, input logic [31:0] rt,
                                   input logic [15:0] im, input logic [4:0] rta,
                                   input logic [4:0] rda);
        exp_t        e;
        logic [31:0] b;
        logic [4:0]  sh;
        longint      full;
        b     = src ? 32'(int'($signed(im))) : rt;
        sh    = im[10:6];
        e.o   = 1'b0;
        e.res = 32'h0;
        case (op)
            6'h00: begin
                e.res = a + b;
                full  = longint'($signed(a)) + longint'($signed(b));
                e.o   = (full != longint'($signed(e.res)));
            end
            6'h01: begin
                e.res = a - b;
                full  = longint'($signed(a)) - longint'($signed(b));
                e.o   = (full != longint'($signed(e.res)));
            end
            6'h02: e.res = a & b;
            6'h03: e.res = a | b;
            6'h04: e.res = a ^ b;
            6'h05: e.res = ~(a | b);
            6'h06: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h07: e.res = (a < b) ? 32'd1 : 32'd0;
            6'h08: e.res = b << sh;
            6'h09: e.res = b >> sh;
            6'h0A: e.res = $signed(b) >>> sh;
            6'h0B: e.res = {im, 16'h0};
            6'h0C: e.res = a * b;
            default: e.res = 32'h0;
        endcase
        e.z  = (e.res == 32'h0);
        e.wa = dst ? rda : rta;
        return e;
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else                 out_ready = (ready_mode == 1);
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks held outputs
    initial begin
        exp_t        e;
        logic        hold;
        logic [31:0] p_res;
        logic [4:0]  p_wa;
        logic        p_z, p_o;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_result", result, p_res);
                chk("hold_fields", 32'({wr_addr, zero, ovf}), 32'({p_wa, p_z, p_o}));
            end
            hold  = (rst === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b0);
            p_res = result;
            p_wa  = wr_addr;
            p_z   = zero;
            p_o   = ovf;
            if ((rst === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h with no pending expectation", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", result, e.res);
                    chk("sb_wr_addr", 32'(wr_addr), 32'(e.wa));
                    chk("sb_zero_ovf", 32'({zero, ovf}), 32'({e.z, e.o}));
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic src, input logic dst,
                          input logic [31:0] a, input logic [31:0] rt, input logic [15:0] im,
                          input logic [4:0] rta, input logic [4:0] rda);
        alu_op_reg  = op;
        alu_src_reg = src;
        reg_dst_reg = dst;
        rs_data     = a;
        rt_data     = rt;
        imm         = im;
        rt_addr     = rta;
        rd_addr     = rda;
        in_valid    = 1'b1;
    endtask

    // Waits for the held instruction to be taken; pushes its expectation at that moment
    task automatic wait_accept(output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (stall === 1'b0) begin
                exp_q.push_back(model(alu_op_reg, alu_src_reg, reg_dst_reg, rs_data,
                                      rt_data, imm, rt_addr, rd_addr));
                acc_cyc = cyc;
                done    = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got stall held 300 cycles expected accept");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic src, input logic dst,
                         input logic [31:0] a, input logic [31:0] rt, input logic [15:0] im,
                         input logic [4:0] rta, input logic [4:0] rda, output int acc_cyc);
        set_in(op, src, dst, a, rt, im, rta, rda);
        wait_accept(acc_cyc);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 8));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          ac;
        int          n_stall, ov_cyc, n_ov;
        logic [5:0]  op;
        logic [31:0] mul_res;

        rst = 1'b0;
        set_in(6'h00, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'h0, 5'h0);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_fields", 32'({wr_addr, zero, ovf}), 32'd0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();

        // ADD overflow
        issue(6'h00, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd2, 5'd3, ac);
        @(negedge clk);
        chk("add_ovf_valid", 32'(out_valid), 32'd1);
        chk("add_ovf_result", result, 32'h80000000);
        chk("add_ovf_flags", 32'({zero, ovf}), 32'b01);
        step();

        // SUB to zero with rd destination, then ADD with sign-extended immediate
        issue(6'h01, 1'b0, 1'b1, 32'd5, 32'd5, 16'h0, 5'd3, 5'd7, ac);
        @(negedge clk);
        chk("sub_zero_result", result, 32'h0);
        chk("sub_zero_flag", 32'(zero), 32'd1);
        chk("sub_wr_addr", 32'(wr_addr), 32'd7);
        step();
        issue(6'h00, 1'b1, 1'b0, 32'd1, 32'h12345678, 16'hFFFF, 5'd4, 5'd5, ac);
        @(negedge clk);
        chk("addi_result", result, 32'h0);
        chk("addi_zero", 32'(zero), 32'd1);
        step();

        // Shifts and compares
        issue(6'h0A, 1'b0, 1'b0, 32'h0, 32'h80000000, 16'h0100, 5'd6, 5'd0, ac);
        @(negedge clk);
        chk("sra_result", result, 32'hF8000000);
        step();
        issue(6'h07, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd8, 5'd0, ac);
        @(negedge clk);
        chk("sltu_result", result, 32'h0);
        step();
        issue(6'h06, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd8, 5'd0, ac);
        @(negedge clk);
        chk("slt_result", result, 32'h1);
        step();
        issue(6'h0B, 1'b1, 1'b0, 32'h0, 32'h0, 16'hABCD, 5'd9, 5'd0, ac);
        @(negedge clk);
        chk("lui_result", result, 32'hABCD0000);
        step();
        issue(6'h3F, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd10, 5'd0, ac);
        @(negedge clk);
        chk("undef_op", 32'({result[0], zero, ovf}), 32'b010);
        step();

        // MUL: stall span and latency
        issue(6'h0C, 1'b0, 1'b0, 32'h00012345, 32'h00000100, 16'h0, 5'd11, 5'd0, ac);
        n_stall = 0;
        ov_cyc  = -1;
        mul_res = 32'h0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            else       @(negedge clk);
            if (stall === 1'b1) n_stall++;
            if (out_valid === 1'b1 && ov_cyc < 0) begin
                ov_cyc  = cyc;
                mul_res = result;
            end
        end
        chk("mul_stall_cycles", 32'(n_stall), 32'd33);
        chk("mul_latency_edges", 32'(ov_cyc - (ac + 1)), 32'd33);
        chk("mul_result", mul_res, 32'h01234500);
        step();

        // Back-pressure: result held, next instruction stalled, then back-to-back
        ready_mode = 0;
        issue(6'h02, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd12, 5'd0, ac);
        set_in(6'h03, 1'b0, 1'b1, 32'h0000000F, 32'h00000F00, 16'h0, 5'd0, 5'd13);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_stall", 32'(stall), 32'd1);
            chk("bp_held_result", result, 32'hF000F000);
        end
        step();
        ready_mode = 1;
        wait_accept(ac);
        @(negedge clk);
        chk("bp_b2b_valid", 32'(out_valid), 32'd1);
        chk("bp_b2b_result", result, 32'h00000F0F);
        step();

        // Reset during MUL step 10 aborts the multiply
        issue(6'h0C, 1'b0, 1'b0, 32'h00000003, 32'h00000005, 16'h0, 5'd14, 5'd0, ac);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mul_stall_low", 32'(stall), 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mul_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul_idle", 32'(stall), 32'd0);
        n_ov = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n_ov++;
        end
        chk("rst_mul_no_output", 32'(n_ov), 32'd0);
        step();

        // Randomized traffic with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 250; i++) begin
            op = 6'($urandom_range(0, 15));
            if (op == 6'h0C && $urandom_range(0, 2) != 0) op = 6'h00;
            if (op == 6'h0D) op = 6'($urandom_range(13, 63));
            issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_word(),
                  rand_word(), 16'($urandom), 5'($urandom), 5'($urandom), ac);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end

        ready_mode = 1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
